// File: rtl/lc3_branch_pkg.sv
`default_nettype none
// ============================================================================
// Package : lc3_branch_pkg
// Purpose : Shared types and constants for the LC-3 branch resolver:
//           FSM state encoding, BR opcode, instruction field positions and
//           the 9-bit PC-offset sign extension helper.
// Revision: 1.0 - initial release
// ============================================================================
package lc3_branch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_BR = 4'b0000;

   // Instruction field positions
   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int MASK_MSB = 11;
   localparam int MASK_LSB = 9;
   localparam int OFF_MSB  = 8;
   localparam int OFF_LSB  = 0;

   function automatic logic [15:0] sext9(input logic [8:0] off);
      return {{7{off[8]}}, off};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_branch_resolver_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : W-bit up counter that sticks at all-ones. Synchronous clear has
//           priority over increment.
// Ports   : clk_i  - clock, rising edge
//           rst_ni - asynchronous active-low reset (count -> 0)
//           clr_i  - synchronous clear
//           inc_i  - increment request
//           cnt_o  - current count
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/lc3_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module  : lc3_branch_resolver
// Purpose : Snapshots a BR instruction, the condition codes and the
//           incremented PC on a start pulse, evaluates branch-enable and the
//           PC-relative target one cycle later, and offers the result on a
//           valid/ready handshake. Keeps saturating taken / not-taken
//           statistics counters that advance on each accepted result.
// Ports   : Clk          - clock, rising edge
//           Reset_n      - asynchronous active-low reset
//           start        - request (sampled only in IDLE)
//           ir[15:0]     - instruction word
//           nzp[2:0]     - condition codes {N,Z,P}
//           pc[15:0]     - incremented PC
//           busy         - state is not IDLE
//           result_valid - result fields valid, held until accepted
//           result_ready - consumer accepts result
//           ben          - branch enable
//           target[15:0] - pc + sext(PCoffset9)
//           illegal      - captured opcode was not BR
//           clr_stats    - synchronous clear of both counters
//           taken_cnt    - accepted results with ben=1 (saturating)
//           nottaken_cnt - accepted results with ben=0 (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module lc3_branch_resolver
   import lc3_branch_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             start,
   input  logic [15:0]      ir,
   input  logic [2:0]       nzp,
   input  logic [15:0]      pc,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             ben,
   output logic [15:0]      target,
   output logic             illegal,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] nottaken_cnt
);

   state_t      state_q, state_d;

   // Snapshot of the request
   logic [15:0] ir_q;
   logic [2:0]  nzp_q;
   logic [15:0] pc_q;

   // Registered result
   logic        ben_q;
   logic [15:0] target_q;
   logic        illegal_q;

   logic        load_snap;
   logic        load_res;
   logic        accept;

   logic        eval_illegal;
   logic        eval_ben;
   logic [15:0] eval_target;

   // ---------------------------------------------------------------------
   // Evaluation from snapshot only, so nzp/ir changes after start are moot
   // ---------------------------------------------------------------------
   assign eval_illegal = (ir_q[OP_MSB:OP_LSB] != OP_BR);
   assign eval_ben     = (|(ir_q[MASK_MSB:MASK_LSB] & nzp_q)) & ~eval_illegal;
   // Target is always produced, even for illegal or not-taken results
   assign eval_target  = pc_q + sext9(ir_q[OFF_MSB:OFF_LSB]);

   // ---------------------------------------------------------------------
   // FSM next-state / control
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      load_snap = 1'b0;
      load_res  = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load_snap = 1'b1;
               state_d   = EVAL;
            end
         end
         EVAL: begin
            load_res = 1'b1;
            state_d  = RESP;
         end
         RESP: begin
            if (result_ready) begin
               accept  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ir_q  <= '0;
         nzp_q <= '0;
         pc_q  <= '0;
      end else if (load_snap) begin
         ir_q  <= ir;
         nzp_q <= nzp;
         pc_q  <= pc;
      end
   end

   // Result fields persist after accept until the next EVAL
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ben_q     <= 1'b0;
         target_q  <= '0;
         illegal_q <= 1'b0;
      end else if (load_res) begin
         ben_q     <= eval_ben;
         target_q  <= eval_target;
         illegal_q <= eval_illegal;
      end
   end

   // ---------------------------------------------------------------------
   // Statistics counters advance on the accept edge only
   // ---------------------------------------------------------------------
   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (clr_stats),
      .inc_i  (accept & ben_q),
      .cnt_o  (taken_cnt)
   );

   sat_counter #(.W(CNT_W)) u_nottaken_cnt (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (clr_stats),
      .inc_i  (accept & ~ben_q),
      .cnt_o  (nottaken_cnt)
   );

   // Status outputs are pure decodes of the state register
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == RESP);
   assign ben          = ben_q;
   assign target       = target_q;
   assign illegal      = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3_branch_resolver
// Purpose : Self-checking bench for lc3_branch_resolver (CNT_W=2). A driver
//           issues directed branch requests and pushes hand-computed results
//           into a queue; a monitor pops and compares whenever result_valid
//           is presented. Counter values follow a small saturating model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lc3_branch_resolver;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             Clk;
   logic             Reset_n;
   logic             start;
   logic [15:0]      ir;
   logic [2:0]       nzp;
   logic [15:0]      pc;
   logic             busy;
   logic             result_valid;
   logic             result_ready;
   logic             ben;
   logic [15:0]      target;
   logic             illegal;
   logic             clr_stats;
   logic [CNT_W-1:0] taken_cnt;
   logic [CNT_W-1:0] nottaken_cnt;

   lc3_branch_resolver #(.CNT_W(CNT_W)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .start        (start),
      .ir           (ir),
      .nzp          (nzp),
      .pc           (pc),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .ben          (ben),
      .target       (target),
      .illegal      (illegal),
      .clr_stats    (clr_stats),
      .taken_cnt    (taken_cnt),
      .nottaken_cnt (nottaken_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        ben;
      logic [15:0] tgt;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_taken = 0;
   int   exp_nt    = 0;
   logic prev_v    = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Monitor: compares every cycle the result is presented, which also
   // covers field stability under backpressure.
   initial begin
      cur = '{ben: 1'b0, tgt: 16'h0, ill: 1'b0};
      forever begin
         @(negedge Clk);
         if (result_valid === 1'b1) begin
            if (prev_v !== 1'b1) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_result: got result with empty queue, expected none");
               end else begin
                  cur = exp_q.pop_front();
               end
            end
            chk("mon_ben",     {31'd0, ben},     {31'd0, cur.ben});
            chk("mon_target",  {16'd0, target},  {16'd0, cur.tgt});
            chk("mon_illegal", {31'd0, illegal}, {31'd0, cur.ill});
         end
         prev_v = result_valid;
      end
   end

   // Issue one request; hold ready low for 'hold' cycles once valid is up.
   task automatic run_br(input logic [15:0] i_ir, input logic [2:0] i_nzp,
                         input logic [2:0] i_nzp_late, input logic [15:0] i_pc,
                         input logic e_ben, input logic [15:0] e_tgt,
                         input logic e_ill, input int hold, input bit clr_acc);
      exp_t e;
      e.ben = e_ben;
      e.tgt = e_tgt;
      e.ill = e_ill;
      exp_q.push_back(e);
      @(negedge Clk);
      ir = i_ir; nzp = i_nzp; pc = i_pc; start = 1'b1; result_ready = 1'b0;
      @(negedge Clk);
      start = 1'b0;
      nzp   = i_nzp_late;
      chk("busy_after_start",  {31'd0, busy},         32'd1);
      chk("valid_after_start", {31'd0, result_valid}, 32'd0);
      @(negedge Clk);
      chk("valid_latency2",    {31'd0, result_valid}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         if (h == 2) begin
            start = 1'b1; ir = 16'h0E00; nzp = 3'b111; pc = 16'hAAAA;
         end
         @(negedge Clk);
         start = 1'b0;
         chk("bp_busy",  {31'd0, busy},         32'd1);
         chk("bp_valid", {31'd0, result_valid}, 32'd1);
         chk("bp_taken", {30'd0, taken_cnt},    exp_taken);
         chk("bp_nt",    {30'd0, nottaken_cnt}, exp_nt);
      end
      result_ready = 1'b1;
      clr_stats    = clr_acc;
      if (clr_acc) begin
         exp_taken = 0;
         exp_nt    = 0;
      end else if (e_ben) begin
         if (exp_taken < CNT_MAX) exp_taken++;
      end else begin
         if (exp_nt < CNT_MAX) exp_nt++;
      end
      @(negedge Clk);
      result_ready = 1'b0;
      clr_stats    = 1'b0;
      chk("valid_after_accept", {31'd0, result_valid}, 32'd0);
      chk("busy_after_accept",  {31'd0, busy},         32'd0);
      chk("taken_cnt",          {30'd0, taken_cnt},    exp_taken);
      chk("nottaken_cnt",       {30'd0, nottaken_cnt}, exp_nt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset_n = 1'b0; start = 1'b0; ir = '0; nzp = '0; pc = '0;
      result_ready = 1'b0; clr_stats = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_busy",    {31'd0, busy},         32'd0);
      chk("rst_valid",   {31'd0, result_valid}, 32'd0);
      chk("rst_ben",     {31'd0, ben},          32'd0);
      chk("rst_target",  {16'd0, target},       32'd0);
      chk("rst_illegal", {31'd0, illegal},      32'd0);
      chk("rst_taken",   {30'd0, taken_cnt},    32'd0);
      chk("rst_nt",      {30'd0, nottaken_cnt}, 32'd0);
      Reset_n = 1'b1;

      // BRz, offset -1, taken
      run_br(16'h05FF, 3'b010, 3'b010, 16'h3001, 1'b1, 16'h3000, 1'b0, 0, 1'b0);
      // BRn with P set: not taken
      run_br(16'h0805, 3'b001, 3'b001, 16'h3000, 1'b0, 16'h3005, 1'b0, 0, 1'b0);
      // BRnzp with reset-value codes never takes
      run_br(16'h0E00, 3'b000, 3'b000, 16'h3005, 1'b0, 16'h3005, 1'b0, 0, 1'b0);
      // BRp under 5 cycles of backpressure with an ignored start inside
      run_br(16'h0203, 3'b001, 3'b001, 16'h4000, 1'b1, 16'h4003, 1'b0, 5, 1'b0);
      // Snapshot: nzp moves from Z to N after the start edge
      run_br(16'h05FF, 3'b010, 3'b100, 16'h3001, 1'b1, 16'h3000, 1'b0, 0, 1'b0);
      // ADD opcode: illegal, ben forced low even though mask matches
      run_br(16'h1234, 3'b001, 3'b001, 16'h1000, 1'b0, 16'h1034, 1'b1, 0, 1'b0);
      // Target wraps; taken counter already at 3 so it saturates
      run_br(16'h0E01, 3'b100, 3'b100, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 0, 1'b0);

      // Standalone clear
      @(negedge Clk);
      clr_stats = 1'b1;
      @(negedge Clk);
      clr_stats = 1'b0;
      exp_taken = 0;
      exp_nt    = 0;
      chk("clr_taken", {30'd0, taken_cnt},    32'd0);
      chk("clr_nt",    {30'd0, nottaken_cnt}, 32'd0);

      // Five taken branches saturate the 2-bit counter at 3
      for (int i = 0; i < 5; i++) begin
         run_br(16'h0E10, 3'b001, 3'b001, 16'h0100 + 16'(i), 1'b1,
                16'h0110 + 16'(i), 1'b0, 0, 1'b0);
      end
      // Negative offset -256 with clear on the accept edge
      run_br(16'h0900, 3'b100, 3'b100, 16'h0050, 1'b1, 16'hFF50, 1'b0, 0, 1'b1);

      // Reset during EVAL abandons the request
      @(negedge Clk);
      ir = 16'h05FF; nzp = 3'b010; pc = 16'h3001; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      #1 Reset_n = 1'b0;
      #1;
      chk("mid_rst_busy",    {31'd0, busy},         32'd0);
      chk("mid_rst_valid",   {31'd0, result_valid}, 32'd0);
      chk("mid_rst_ben",     {31'd0, ben},          32'd0);
      chk("mid_rst_target",  {16'd0, target},       32'd0);
      chk("mid_rst_illegal", {31'd0, illegal},      32'd0);
      chk("mid_rst_taken",   {30'd0, taken_cnt},    32'd0);
      chk("mid_rst_nt",      {30'd0, nottaken_cnt}, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      exp_taken = 0;
      exp_nt    = 0;
      run_br(16'h05FF, 3'b010, 3'b010, 16'h3001, 1'b1, 16'h3000, 1'b0, 0, 1'b0);

      repeat (2) @(negedge Clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
